data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Data-memory responder that serves the load/store requests issued by the multicycle control FSM during its MEMORY state. It accepts one request per handshake, performs byte, half-word or word accesses on a word-organised RAM with byte-lane write masking, and returns sign- or zero-extended load data with a one-cycle `ready` pulse. It sits between the control/datapath and the data RAM.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words; power of two.
- `LATENCY`, 1: access cycles before response; legal range 1..4.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `read_enable`  in  1  load request (level).
- `write_enable`  in  1  store request (level).
- `mem_type`  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 110 HU.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data; the low byte or half-word is used for B and H stores.
- `rdata`  out  32  extended load data.
- `ready`  out  1  one-cycle completion pulse.
- `err`  out  1  error flag, valid while `ready` is high.
- `busy`  out  1  high from acceptance until the end of the RESP state.

## Operation
- States:
  - IDLE
  - ACCESS: counts `LATENCY` cycles.
  - RESP
  - RELEASE
- IDLE:
  - If `read_enable | write_enable` is high, latch `addr`, `wdata`, `mem_type` and direction, then go to ACCESS.
  - Changes to the inputs after acceptance are ignored.
- Error check at acceptance. Any of the following sets error: both enables high; illegal `mem_type`; store with BU or HU; H or HU with `addr[0]` = 1; W with `addr[1:0]` ≠ 0.
- Errored requests still run the full ACCESS/RESP sequence, perform no RAM write, and return `rdata` = 0 with `err` = 1.
- Word index is `addr[$clog2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so accesses wrap modulo the RAM size.
- Store byte-lane mask:
  - B: `1 << addr[1:0]`
  - H: `0011` or `1100`, selected by `addr[1]`
  - W: `1111`
  - Data is replicated across lanes. Unmasked bytes are unchanged.
- Store commit: the write is issued on the final ACCESS cycle only.
- Load: read the word, select the lane, then extend. B and H are sign-extended; BU and HU are zero-extended; W is passed through.
- RESP: assert `ready` = 1 for exactly one cycle and drive the final `rdata`/`err`, then go to RELEASE.
- RELEASE: wait until both enables are low, then go to IDLE. An enable held high after a response never causes a second access.
- `rdata` holds its value until the next load response or reset. `err` is cleared when `ready` falls.

## Timing
- Request seen in IDLE at edge 0 leads to:
  - ACCESS from edge 1 through edge `LATENCY`;
  - RESP, with `ready` high, in cycle `LATENCY`+1;
  - RELEASE from cycle `LATENCY`+2.
- `busy` rises on the acceptance edge and falls when the block leaves RESP.
- Minimum spacing between request acceptances is `LATENCY`+3 cycles, because both enables must be observed low in RELEASE.
- Reset values: `rdata` = 0, `ready` = 0, `err` = 0, `busy` = 0, state = IDLE, counter = 0. RAM contents are not reset.
- Reset mid-operation aborts immediately.
  - A store is not committed if `rst_n` falls before the final ACCESS edge.
  - No `ready` pulse is produced.
- The ACCESS counter width is `$clog2(LATENCY+1)`; it resets to 0 on entry to ACCESS.

## Structure
- Package `mem_pkg` holds:
  - the `mem_type_e` enum with the encodings above;
  - the `resp_state_e` state enum;
  - the constants `MT_B`, `MT_H`, `MT_W`, `MT_BU`, `MT_HU`.
- Sub-module `data_ram`:
  - `DEPTH_WORDS` × 32 synchronous RAM;
  - 4-bit byte-write enable, word index and 32-bit write data;
  - registered read, one cycle.
- `data_mem_responder` contains the FSM, counter, lane mask, extension logic and error check.

## Test plan
- SW `0xDEADBEEF` @ `0x10`, then LW @ `0x10` → `rdata` = `0xDEADBEEF`, `err` = 0; `ready` is high exactly in cycle `LATENCY`+1 after acceptance.
- SB `wdata` = `0x00000080` @ `0x13` over the word above, then:
  - LB @ `0x13` → `0xFFFFFF80`;
  - LBU → `0x00000080`;
  - LW @ `0x10` → `0x80ADBEEF`.
- SH `0x1234` @ `0x21` → `err` = 1, `ready` = 1, and a following LW @ `0x20` returns the prior value unchanged. LW with `read_enable` and `write_enable` both high → `err` = 1, `rdata` = 0.
- With `LATENCY` = 3, hold `read_enable` high for 20 cycles → exactly one `ready` pulse, at cycle 4. Drop `read_enable`, raise it again → a second pulse 4 cycles after acceptance.
- SW `0xCAFEF00D` @ `0x40` with `rst_n` pulsed low during the first ACCESS cycle → all outputs are 0 immediately, and a later LW @ `0x40` returns the pre-store value.
- SW @ `DEPTH_WORDS*4 + 0x8` then LW @ `0x8` → the same data, confirming address wrap.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory responder: access types and FSM states.
package mem_pkg;

  typedef enum logic [2:0] {
    MT_B  = 3'b000,
    MT_H  = 3'b001,
    MT_W  = 3'b010,
    MT_BU = 3'b100,
    MT_HU = 3'b110
  } mem_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP,
    ST_RELEASE
  } resp_state_e;

endpackage

// File: rtl/data_ram.sv
// Word-organised synchronous RAM built from four byte lanes; one-cycle registered read.
module data_ram #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic [3:0]                     be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH_WORDS];
    logic [7:0] q_reg;

    always_ff @(posedge clk) begin
      if (be[gi]) lane_mem[idx] <= wdata[gi*8 +: 8];
      q_reg <= lane_mem[idx];
    end

    assign rdata[gi*8 +: 8] = q_reg;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: accepts one request per handshake, runs a fixed-latency
// access on data_ram, and returns extended load data with a one-cycle ready pulse.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [2:0]  mem_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int IDXW = $clog2(DEPTH_WORDS);
  localparam int CW   = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] LAST = CW'(LATENCY - 1);

  resp_state_e     state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [IDXW-1:0] idx_reg;
  logic [1:0]      off_reg;
  logic [31:0]     wdata_reg;
  logic [2:0]      type_reg;
  logic            write_reg;
  logic            req_err_reg;

  logic            req_err;
  logic [3:0]      lane_mask;
  logic [31:0]     lane_wdata;
  logic [31:0]     ram_q;
  logic [31:0]     lane_word;
  logic [31:0]     load_val;
  logic [IDXW-1:0] ram_idx;
  logic [3:0]      ram_be;
  logic            last_access;
  logic            unused_addr;

  assign unused_addr = ^addr[31:IDXW+2];

  always_comb begin
    req_err = read_enable & write_enable;
    case (mem_type)
      MT_B, MT_BU: ;
      MT_H, MT_HU: if (addr[0]) req_err = 1'b1;
      MT_W:        if (addr[1:0] != 2'b00) req_err = 1'b1;
      default:     req_err = 1'b1;
    endcase
    if (write_enable && (mem_type == MT_BU || mem_type == MT_HU)) req_err = 1'b1;
  end

  always_comb begin
    lane_mask  = 4'b0000;
    lane_wdata = wdata_reg;
    case (type_reg)
      MT_B: begin
        lane_mask  = 4'b0001 << off_reg;
        lane_wdata = {4{wdata_reg[7:0]}};
      end
      MT_H: begin
        lane_mask  = off_reg[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata_reg[15:0]}};
      end
      MT_W:    lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  end

  always_comb begin
    lane_word = ram_q >> {off_reg, 3'b000};
    case (type_reg)
      MT_B:    load_val = {{24{lane_word[7]}}, lane_word[7:0]};
      MT_H:    load_val = {{16{lane_word[15]}}, lane_word[15:0]};
      MT_BU:   load_val = {24'h0, lane_word[7:0]};
      MT_HU:   load_val = {16'h0, lane_word[15:0]};
      default: load_val = lane_word;
    endcase
  end

  // Reads are steered from the live address in IDLE so the registered RAM output
  // is already valid on the first ACCESS cycle, even with LATENCY = 1.
  assign last_access = (state_reg == ST_ACCESS) && (cnt_reg == LAST);
  assign ram_idx     = (state_reg == ST_IDLE) ? addr[IDXW+1:2] : idx_reg;
  assign ram_be      = (last_access && write_reg && !req_err_reg) ? lane_mask : 4'b0000;

  data_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .be    (ram_be),
    .idx   (ram_idx),
    .wdata (lane_wdata),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      idx_reg     <= '0;
      off_reg     <= 2'b00;
      wdata_reg   <= 32'h0;
      type_reg    <= 3'b000;
      write_reg   <= 1'b0;
      req_err_reg <= 1'b0;
      rdata       <= 32'h0;
      ready       <= 1'b0;
      err         <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (read_enable | write_enable) begin
            idx_reg     <= addr[IDXW+1:2];
            off_reg     <= addr[1:0];
            wdata_reg   <= wdata;
            type_reg    <= mem_type;
            write_reg   <= write_enable;
            req_err_reg <= req_err;
            cnt_reg     <= '0;
            busy        <= 1'b1;
            state_reg   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt_reg == LAST) begin
            ready <= 1'b1;
            err   <= req_err_reg;
            if (req_err_reg)     rdata <= 32'h0;
            else if (!write_reg) rdata <= load_val;
            state_reg <= ST_RESP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_RESP: begin
          ready     <= 1'b0;
          err       <= 1'b0;
          busy      <= 1'b0;
          state_reg <= ST_RELEASE;
        end
        default: begin
          if (!read_enable && !write_enable) state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a vector table of single requests plus
// hand-written sequences for held enables and mid-access reset.
module tb_data_mem_responder;
  import mem_pkg::*;

  localparam int DEPTH = 64;
  localparam int LAT   = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        read_enable = 1'b0;
  logic        write_enable = 1'b0;
  logic [2:0]  mem_type = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;

  int passed = 0;
  int total  = 0;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .read_enable  (read_enable),
    .write_enable (write_enable),
    .mem_type     (mem_type),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .ready        (ready),
    .err          (err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        re;
    logic        we;
    logic [2:0]  mt;
    logic [31:0] a;
    logic [31:0] wd;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else passed++;
  endtask

  // Issues one request, returns the response and the number of edges from acceptance to ready.
  task automatic xact(input logic re, input logic we, input logic [2:0] mt,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    read_enable = re; write_enable = we; mem_type = mt; addr = a; wdata = wd;
    @(posedge clk); #1;
    check("busy_on_accept", {31'h0, busy}, 32'h1);
    addr = 32'hFFFF_FFFC; wdata = 32'h5555_5555; mem_type = 3'b010;
    lat = -1; rd = 32'hx; er = 1'bx;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (ready) begin
        lat = n; rd = rdata; er = err;
        break;
      end
    end
    read_enable = 1'b0; write_enable = 1'b0;
    @(posedge clk); #1;
    check("ready_err_busy_after_resp", {29'h0, ready, err, busy}, 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          pulses;
    int          first;

    //          re  we  type    addr          wdata         chk rd exp_rd        err
    vecs[0]  = '{1'b0, 1'b1, MT_W,  32'h10,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 1'b0, MT_W,  32'h10,  32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, MT_B,  32'h13,  32'h00000080, 1'b1, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, MT_B,  32'h13,  32'h0,        1'b1, 32'hFFFFFF80, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, MT_BU, 32'h13,  32'h0,        1'b1, 32'h00000080, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, MT_W,  32'h10,  32'h0,        1'b1, 32'h80ADBEEF, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, MT_H,  32'h12,  32'h0,        1'b1, 32'hFFFF80AD, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, MT_HU, 32'h12,  32'h0,        1'b1, 32'h000080AD, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, MT_B,  32'h11,  32'h0,        1'b1, 32'hFFFFFFBE, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, MT_W,  32'h20,  32'h11112222, 1'b0, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 1'b1, MT_H,  32'h21,  32'h00001234, 1'b1, 32'h0,        1'b1};
    vecs[11] = '{1'b1, 1'b0, MT_W,  32'h20,  32'h0,        1'b1, 32'h11112222, 1'b0};
    vecs[12] = '{1'b1, 1'b1, MT_W,  32'h20,  32'h0,        1'b1, 32'h0,        1'b1};
    vecs[13] = '{1'b0, 1'b1, MT_H,  32'h22,  32'h00007654, 1'b0, 32'h0,        1'b0};
    vecs[14] = '{1'b1, 1'b0, MT_W,  32'h20,  32'h0,        1'b1, 32'h76542222, 1'b0};
    vecs[15] = '{1'b1, 1'b0, MT_H,  32'h20,  32'h0,        1'b1, 32'h00002222, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 3'b011, 32'h20, 32'h0,        1'b1, 32'h0,        1'b1};
    vecs[17] = '{1'b1, 1'b0, MT_W,  32'h22,  32'h0,        1'b1, 32'h0,        1'b1};
    vecs[18] = '{1'b0, 1'b1, MT_BU, 32'h20,  32'h000000FF, 1'b1, 32'h0,        1'b1};
    vecs[19] = '{1'b1, 1'b0, MT_W,  32'h20,  32'h0,        1'b1, 32'h76542222, 1'b0};
    vecs[20] = '{1'b0, 1'b1, MT_W,  DEPTH*4 + 32'h8, 32'hA5A55A5A, 1'b0, 32'h0, 1'b0};
    vecs[21] = '{1'b1, 1'b0, MT_W,  32'h8,   32'h0,        1'b1, 32'hA5A55A5A, 1'b0};
    vecs[22] = '{1'b0, 1'b1, MT_W,  32'h40,  32'h0BADCAFE, 1'b1, 32'hA5A55A5A, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {rdata[30:0], ready}, 32'h0);
    check("reset_err_busy", {30'h0, err, busy}, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      xact(vecs[i].re, vecs[i].we, vecs[i].mt, vecs[i].a, vecs[i].wd, rd, er, lat);
      $display("vec %0d: re=%0b we=%0b type=%03b addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d",
               i, vecs[i].re, vecs[i].we, vecs[i].mt, vecs[i].a, vecs[i].wd, rd, er, lat);
      check($sformatf("vec%0d_latency", i), lat, LAT);
      check($sformatf("vec%0d_err", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
    end

    // Held read_enable must yield a single response.
    @(negedge clk);
    read_enable = 1'b1; mem_type = MT_W; addr = 32'h10;
    pulses = 0; first = -1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (ready) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    read_enable = 1'b0;
    $display("hold: pulses=%0d first=%0d", pulses, first);
    check("hold_pulse_count", pulses, 1);
    check("hold_pulse_cycle", first, LAT);
    repeat (2) @(posedge clk);
    xact(1'b1, 1'b0, MT_W, 32'h10, 32'h0, rd, er, lat);
    $display("reraise: rdata=%h err=%0b lat=%0d", rd, er, lat);
    check("reraise_latency", lat, LAT);
    check("reraise_rdata", rd, 32'h80ADBEEF);

    // Reset during the first ACCESS cycle aborts the store.
    @(negedge clk);
    write_enable = 1'b1; mem_type = MT_W; addr = 32'h40; wdata = 32'hCAFEF00D;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    $display("midreset: rdata=%h ready=%0b err=%0b busy=%0b", rdata, ready, err, busy);
    check("midreset_rdata", rdata, 32'h0);
    check("midreset_flags", {29'h0, ready, err, busy}, 32'h0);
    write_enable = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    xact(1'b1, 1'b0, MT_W, 32'h40, 32'h0, rd, er, lat);
    $display("after reset: rdata=%h err=%0b lat=%0d", rd, er, lat);
    check("no_commit_rdata", rd, 32'h0BADCAFE);
    check("no_commit_latency", lat, LAT);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
